wb_cmd_master: RTL and testbench
================================

// Module: wb_cmd_master
// PURPOSE
//  Wishbone classic initiator for the user project. Converts single-word commands from internal
//  logic (valid/ready) into Wishbone B4 classic single read/write cycles, then returns data/status
//  on a response channel. Counterpart of the user-area Wishbone slave port; one transfer in flight.
// PARAMETERS
//  AW          32   address width (wbm_adr_o)
//  DW          32   data width; wbm_sel_o is DW/8 bits
//  TIMEOUT     255  max cycles with stb high and no ack/err before abort; 0 disables timeout
// PORTS
//  wb_clk_i     in   1      clock, all logic on rising edge
//  wb_rst_ni    in   1      async active-low reset
//  cmd_valid_i  in   1      command present
//  cmd_ready_o  out  1      command accepted when valid&ready
//  cmd_we_i     in   1      1=write, 0=read
//  cmd_adr_i    in   AW     byte address
//  cmd_dat_i    in   DW     write data
//  cmd_sel_i    in   DW/8   byte enables
//  rsp_valid_o  out  1      response present
//  rsp_ready_i  in   1      response consumed when valid&ready
//  rsp_dat_o    out  DW     read data (0 for writes and errors)
//  rsp_err_o    out  1      1 = bus error or timeout
//  rsp_tmo_o    out  1      1 = timeout (subset of err)
//  wbm_cyc_o    out  1      Wishbone cycle
//  wbm_stb_o    out  1      Wishbone strobe
//  wbm_we_o     out  1      Wishbone write enable
//  wbm_sel_o    out  DW/8   Wishbone byte select
//  wbm_adr_o    out  AW     Wishbone address, bits[1:0] forced 0
//  wbm_dat_o    out  DW     Wishbone write data
//  wbm_dat_i    in   DW     Wishbone read data
//  wbm_ack_i    in   1      Wishbone ack
//  wbm_err_i    in   1      Wishbone error
// BEHAVIOUR
//  - Reset (async, wb_rst_ni=0): all outputs 0, state IDLE, counter 0; cyc/stb drop immediately
//    even mid-cycle; no response generated for the aborted transfer.
//  - FSM IDLE -> BUS -> RESP -> IDLE. cmd_ready_o = (state==IDLE), registered-state decode only.
//  - IDLE: on cmd_valid_i, latch we/adr/dat/sel; next cycle cyc=stb=1 with latched values (1-cycle
//    issue latency). Address/data/sel/we stable for the whole BUS state.
//  - BUS: sample ack/err each edge. Priority err > ack > timeout in the same cycle.
//    ack: capture wbm_dat_i (reads only, writes return 0), err=0. err: data 0, err=1.
//    Counter increments each BUS cycle without ack/err; when count==TIMEOUT-1 with no ack/err,
//    abort: err=1, tmo=1. Any exit: next cycle cyc=stb=0, rsp_valid=1, state RESP.
//    Minimum command-to-response: 2 cycles after acceptance for zero-wait-state slave.
//  - RESP: rsp_* held stable until rsp_valid&rsp_ready; then rsp_valid=0, state IDLE. cmd_ready
//    stays 0 in RESP (no overlap); back-to-back transfers have >=1 idle bus cycle between cycles.
//  - ack/err outside BUS ignored. Counter width = clog2(TIMEOUT+1); saturates, never wraps.
//  - TIMEOUT=0: waits forever for ack/err; rsp_tmo_o never asserted.
// STRUCTURE
//  - Package wb_cmd_master_pkg: state enum {IDLE,BUS,RESP}, default AW/DW/TIMEOUT constants.
//  - Sub-module wb_timeout_ctr (clear, enable, expired) instantiated once; rest is flat FSM+regs.
// TESTING
//  1 Write adr=0x3000_0004 dat=0xA5A5_1234 sel=0xF, slave acks next cycle -> one cyc/stb pulse,
//    we=1, rsp_valid 2 cycles after accept, err=0, dat=0.
//  2 Read adr=0x3000_0010 sel=0xF, slave 3 wait states then ack with 0xCAFE_F00D -> rsp_dat=
//    0xCAFE_F00D, err=0, cyc held exactly 4 cycles.
//  3 TIMEOUT=8, slave never responds -> cyc drops after 8 cycles, rsp_err=1, rsp_tmo=1, dat=0.
//  4 ack and err asserted same cycle -> rsp_err=1, tmo=0; cmd_adr=0x...07 -> wbm_adr_o=0x...04.
//  5 rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0 throughout; new cmd accepted
//    cycle after rsp handshake.
//  6 wb_rst_ni pulsed low during BUS -> cyc/stb 0 asynchronously, no rsp_valid after release,
//    next command completes normally.

Source files
------------

// File: rtl/wb_cmd_master_pkg.sv
// Shared constants and state encoding for the Wishbone command initiator.
// Imported by the timeout counter and the top-level FSM.
package wb_cmd_master_pkg;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUS  = 2'd1;
    localparam state_t RESP = 2'd2;

    // A zero TIMEOUT still needs a one-bit counter to keep widths legal.
    function automatic int ctr_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating wait-state counter for the Wishbone initiator.
// expired flags the last allowed cycle; never fires when TIMEOUT is 0.
module wb_timeout_ctr
    import wb_cmd_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW     = ctr_width(TIMEOUT);
    localparam bit            TMO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] CMAX   = TMO_EN ? CW'(TIMEOUT) : '1;
    localparam logic [CW-1:0] CLAST  = TMO_EN ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    // Count idle bus cycles, holding at the ceiling rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CMAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = TMO_EN && (cnt == CLAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic single-transfer initiator.
// Command in, one bus cycle, one response out; one transfer in flight.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            rsp_tmo_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i
);

    localparam int SW = DW / 8;

    state_t          state;
    logic            live;
    logic            we_q;
    logic [AW-1:0]   adr_q;
    logic [DW-1:0]   dat_q;
    logic [SW-1:0]   sel_q;
    logic [DW-1:0]   rsp_dat_q;
    logic            rsp_err_q;
    logic            rsp_tmo_q;
    logic            in_bus;
    logic            accept;
    logic            expired;

    assign in_bus = (state == BUS);
    assign accept = cmd_valid_i && cmd_ready_o;

    wb_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .clear  (!in_bus),
        .enable (in_bus && !wbm_ack_i && !wbm_err_i),
        .expired(expired)
    );

    // Keeps cmd_ready low while reset is asserted and for the first edge after.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) live <= 1'b0;
        else            live <= 1'b1;
    end

    // Transfer sequencing; err outranks ack, both outrank the timeout.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            unique case (1'b1)
                (state == IDLE): if (accept) state <= BUS;
                (state == BUS):
                    if (wbm_err_i || wbm_ack_i || expired) state <= RESP;
                (state == RESP): if (rsp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Command capture; word-aligned address held for the whole bus cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
        end else if (accept) begin
            we_q  <= cmd_we_i;
            adr_q <= {cmd_adr_i[AW-1:2], 2'b00};
            dat_q <= cmd_dat_i;
            sel_q <= cmd_sel_i;
        end
    end

    // Response capture on bus exit; data only survives a clean read ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_tmo_q <= 1'b0;
        end else if (in_bus) begin
            if (wbm_err_i) begin
                rsp_dat_q <= '0;
                rsp_err_q <= 1'b1;
                rsp_tmo_q <= 1'b0;
            end else if (wbm_ack_i) begin
                rsp_dat_q <= we_q ? '0 : wbm_dat_i;
                rsp_err_q <= 1'b0;
                rsp_tmo_q <= 1'b0;
            end else if (expired) begin
                rsp_dat_q <= '0;
                rsp_err_q <= 1'b1;
                rsp_tmo_q <= 1'b1;
            end
        end
    end

    assign cmd_ready_o = live && (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;
    assign wbm_cyc_o   = in_bus;
    assign wbm_stb_o   = in_bus;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: directed cases, then random traffic.
// Expected responses come from a transaction-level model of the slave plan.
module tb_wb_cmd_master;

    localparam int TMO = 8;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_NONE = 3;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          mode;
        int          w;
        logic [31:0] rd;
        int          len;
    } plan_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
        longint      tick;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_tmo;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack = 1'b0;
    logic        wbm_err = 1'b0;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint tick = 0;
    longint last_hs = 0;
    bit     hs_ok = 0;
    bit     junk_en = 0;
    int     stall = 0;

    plan_t plan_q[$];
    rsp_t  exp_q[$];

    wb_cmd_master #(
        .AW(32),
        .DW(32),
        .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .rsp_tmo_o  (rsp_tmo),
        .wbm_cyc_o  (wbm_cyc),
        .wbm_stb_o  (wbm_stb),
        .wbm_we_o   (wbm_we),
        .wbm_sel_o  (wbm_sel),
        .wbm_adr_o  (wbm_adr),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack),
        .wbm_err_i  (wbm_err)
    );

    always #5 clk = ~clk;

    // Edge counter used to time responses and accepts.
    always @(posedge clk) tick <= tick + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    // Transaction-level outcome of one command against its slave plan.
    function automatic rsp_t model(input plan_t p, input longint t_acc);
        rsp_t r;
        r.tick = t_acc + p.len + 1;
        if (p.mode == M_NONE || p.w >= TMO) begin
            r.dat = 0; r.err = 1; r.tmo = 1;
        end else if (p.mode == M_ERR || p.mode == M_BOTH) begin
            r.dat = 0; r.err = 1; r.tmo = 0;
        end else begin
            r.dat = p.we ? 32'h0 : p.rd; r.err = 0; r.tmo = 0;
        end
        return r;
    endfunction

    // Caller is at a negedge; returns one negedge after acceptance.
    task automatic issue(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input int mode, input int w, input logic [31:0] rd,
                         input bit want_rsp, input int len_force);
        plan_t p;
        bit    waited;
        int    n;
        p.we = we; p.adr = adr; p.dat = dat; p.sel = sel;
        p.mode = mode; p.w = w; p.rd = rd;
        if (len_force > 0) p.len = len_force;
        else if (mode == M_NONE || w >= TMO) p.len = TMO;
        else p.len = w + 1;
        cmd_valid = 1; cmd_we = we; cmd_adr = adr;
        cmd_dat = dat; cmd_sel = sel;
        waited = 0;
        n = 0;
        while (!cmd_ready && n < 200) begin
            waited = 1;
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            if (waited && hs_ok) chk("accept_gap", tick, last_hs + 1);
            plan_q.push_back(p);
            if (want_rsp) exp_q.push_back(model(p, tick));
        end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid || wbm_cyc) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Slave: checks bus fields, answers per plan, measures cycle length.
    initial begin : slave
        plan_t cur;
        bit    active;
        int    cnt;
        active = 0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (wbm_cyc) begin
                if (!active) begin
                    if (plan_q.size() == 0) begin
                        chk("unplanned_cyc", 1, 0);
                        cur.mode = M_NONE; cur.len = 0; cur.w = 0;
                        cur.we = wbm_we; cur.adr = wbm_adr;
                        cur.dat = wbm_dat_o; cur.sel = wbm_sel; cur.rd = 0;
                    end else begin
                        cur = plan_q.pop_front();
                    end
                    active = 1;
                    cnt = 0;
                end
                chk("bus_stb", wbm_stb, 1);
                chk("bus_we", wbm_we, cur.we);
                chk("bus_adr", wbm_adr, cur.adr & ~32'h3);
                chk("bus_sel", wbm_sel, cur.sel);
                chk("bus_dat", wbm_dat_o, cur.dat);
                wbm_dat_i = cur.rd;
                if (cnt == cur.w) begin
                    wbm_ack = (cur.mode == M_ACK || cur.mode == M_BOTH);
                    wbm_err = (cur.mode == M_ERR || cur.mode == M_BOTH);
                end else begin
                    wbm_ack = 0;
                    wbm_err = 0;
                end
                cnt++;
            end else begin
                if (active) chk("cyc_len", cnt, cur.len);
                active = 0;
                wbm_ack = junk_en && ($urandom_range(0, 3) == 0);
                wbm_err = junk_en && ($urandom_range(0, 5) == 0);
                wbm_dat_i = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on each new response, checks hold.
    initial begin : monitor
        rsp_t e;
        bit   holding;
        logic [33:0] held;
        holding = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                chk("ready_in_resp", cmd_ready, 0);
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                        e.dat = rsp_dat; e.err = rsp_err;
                        e.tmo = rsp_tmo; e.tick = tick;
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_dat", rsp_dat, e.dat);
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_tmo", rsp_tmo, e.tmo);
                        chk("rsp_latency", tick, e.tick);
                    end
                    held = {rsp_dat, rsp_err, rsp_tmo};
                    holding = 1;
                end else begin
                    chk("rsp_stable", {rsp_dat, rsp_err, rsp_tmo}, held);
                end
                if (stall > 0) begin
                    rsp_ready = 0;
                    stall--;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                if (rsp_ready) begin
                    holding = 0;
                    last_hs = tick;
                    hs_ok = 1;
                end
            end else begin
                holding = 0;
                rsp_ready = $urandom_range(0, 1);
            end
        end
    end

    initial begin : stim
        int mode;
        int w;
        int r;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cyc_stb", {wbm_cyc, wbm_stb}, 0);
        chk("rst_we_sel", {wbm_we, wbm_sel}, 0);
        chk("rst_adr", wbm_adr, 0);
        chk("rst_dat", wbm_dat_o, 0);
        chk("rst_rsp", {rsp_dat, rsp_err, rsp_tmo}, 0);
        #2 rst_n = 1;
        repeat (2) @(negedge clk);

        // Write, zero wait states
        issue(1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, M_ACK, 0,
              32'h1111_2222, 1, 0);
        drain();
        // Read, three wait states
        issue(0, 32'h3000_0010, 32'h0, 4'hF, M_ACK, 3,
              32'hCAFE_F00D, 1, 0);
        drain();
        // Silent slave, timeout abort
        issue(0, 32'h3000_0020, 32'h0, 4'hF, M_NONE, 0, 32'h5, 1, 0);
        drain();
        // Ack on the last allowed cycle still wins over timeout
        issue(0, 32'h3000_0024, 32'h0, 4'h3, M_ACK, TMO - 1,
              32'h7777_0001, 1, 0);
        drain();
        // Ack and err together, unaligned address
        issue(1, 32'h3000_0007, 32'h0BAD_0BAD, 4'h1, M_BOTH, 1,
              32'h9, 1, 0);
        drain();
        // Response stalled five cycles, next command queued behind it
        issue(0, 32'h3000_0030, 32'h0, 4'hF, M_ACK, 0,
              32'h1234_5678, 1, 0);
        stall = 5;
        issue(1, 32'h3000_0034, 32'hDEAD_BEEF, 4'hC, M_ACK, 2, 32'h0, 1, 0);
        drain();

        // Reset during BUS: no response, then a normal transfer
        issue(0, 32'h3000_0040, 32'h0, 4'hF, M_NONE, 0, 32'h0, 0, 2);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_cyc_stb", {wbm_cyc, wbm_stb}, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_cmd_ready", cmd_ready, 0);
        hs_ok = 0;
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        issue(1, 32'h3000_0044, 32'h0102_0304, 4'hF, M_ACK, 1, 32'h0, 1, 0);
        drain();

        // Random traffic with ack/err noise outside the bus cycle
        junk_en = 1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 7);
            w = $urandom_range(0, 5);
            if (r <= 3) mode = M_ACK;
            else if (r == 4) mode = M_ERR;
            else if (r == 5) mode = M_BOTH;
            else if (r == 6) mode = M_NONE;
            else begin
                mode = M_ACK;
                w = $urandom_range(TMO - 2, TMO + 1);
            end
            issue($urandom_range(0, 1), $urandom, $urandom,
                  4'($urandom_range(0, 15)), mode, w, $urandom, 1, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        chk("plan_q_empty", plan_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
